// File: rtl/dispatch_feeder.sv
// Feeds weight/activation line pairs into the dispatcher's ping-pong buffer,
// issues one read per tile and waits for the dispatcher before the next tile.
module dispatch_feeder #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 6,
  parameter int NSLOT  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tiles,
  input  logic [1:0]        cfg_a_mode,
  input  logic [1:0]        cfg_w_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_w_data,
  input  logic [DATA_W-1:0] in_a_data,
  input  logic              disp_done,
  output logic              wen,
  output logic [ADDR_W-1:0] w_write_address,
  output logic [ADDR_W-1:0] a_write_address,
  output logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] a_in,
  output logic              en,
  output logic [ADDR_W-1:0] w_read_address,
  output logic [ADDR_W-1:0] a_read_address,
  output logic [1:0]        a_mode,
  output logic [1:0]        w_mode,
  output logic              busy,
  output logic [CNT_W-1:0]  tile_cnt,
  output logic              job_done
);

  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]        state;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic [ADDR_W-1:0] slot_addr;
  logic [CNT_W-1:0]  ntiles;
  logic [CNT_W-1:0]  cnt_nxt;

  assign cnt_nxt   = tile_cnt + CNT_W'(1);
  assign slot_addr = ADDR_W'(slot);
  assign slot_nxt  = (slot == SLOT_W'(NSLOT - 1)) ? '0
                   : slot + SLOT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      slot            <= '0;
      ntiles          <= '0;
      in_ready        <= 1'b0;
      wen             <= 1'b0;
      en              <= 1'b0;
      w_write_address <= '0;
      a_write_address <= '0;
      w_read_address  <= '0;
      a_read_address  <= '0;
      w_in            <= '0;
      a_in            <= '0;
      a_mode          <= '0;
      w_mode          <= '0;
      busy            <= 1'b0;
      tile_cnt        <= '0;
      job_done        <= 1'b0;
    end else begin
      wen      <= 1'b0;
      en       <= 1'b0;
      job_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ntiles   <= num_tiles;
            a_mode   <= cfg_a_mode;
            w_mode   <= cfg_w_mode;
            busy     <= 1'b1;
            tile_cnt <= '0;
            slot     <= '0;
            if (num_tiles == '0) begin
              state    <= S_FIN;
              job_done <= 1'b1;
            end else begin
              state    <= S_FILL;
              in_ready <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (in_valid && in_ready) begin
            w_in            <= in_w_data;
            a_in            <= in_a_data;
            in_ready        <= 1'b0;
            wen             <= 1'b1;
            w_write_address <= slot_addr;
            a_write_address <= slot_addr;
            state           <= S_WRITE;
          end
        end
        S_WRITE: begin
          en             <= 1'b1;
          w_read_address <= slot_addr;
          a_read_address <= slot_addr;
          state          <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (disp_done) begin
            tile_cnt <= cnt_nxt;
            slot     <= slot_nxt;
            // compare before the increment lands so a full-scale count cannot wrap
            if (cnt_nxt == ntiles) begin
              state    <= S_FIN;
              job_done <= 1'b1;
            end else begin
              state    <= S_FILL;
              in_ready <= 1'b1;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_feeder.sv
// Directed + randomized bench for dispatch_feeder with a tile-level reference
// model: tile i lands in slot i%2, carries the accepted line, bumps tile_cnt to i+1.
module tb_dispatch_feeder;

  localparam int DW = 1024;
  localparam int AW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_tiles = '0;
  logic [1:0]    cfg_a_mode = '0;
  logic [1:0]    cfg_w_mode = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_w_data = '0;
  logic [DW-1:0] in_a_data = '0;
  logic          disp_done = 1'b0;
  logic          wen;
  logic [AW-1:0] w_write_address;
  logic [AW-1:0] a_write_address;
  logic [DW-1:0] w_in;
  logic [DW-1:0] a_in;
  logic          en;
  logic [AW-1:0] w_read_address;
  logic [AW-1:0] a_read_address;
  logic [1:0]    a_mode;
  logic [1:0]    w_mode;
  logic          busy;
  logic [CW-1:0] tile_cnt;
  logic          job_done;

  int ncmp = 0;
  int nerr = 0;

  dispatch_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .cfg_a_mode(cfg_a_mode), .cfg_w_mode(cfg_w_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w_data(in_w_data), .in_a_data(in_a_data),
    .disp_done(disp_done), .wen(wen),
    .w_write_address(w_write_address), .a_write_address(a_write_address),
    .w_in(w_in), .a_in(a_in), .en(en),
    .w_read_address(w_read_address), .a_read_address(a_read_address),
    .a_mode(a_mode), .w_mode(w_mode), .busy(busy),
    .tile_cnt(tile_cnt), .job_done(job_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      ncmp++;
      assert (!(wen && en)) else begin
        nerr++;
        $error("FAIL wen_en_overlap observed=%b%b expected=not 11", wen, en);
      end
    end
  end

  function automatic logic [DW-1:0] rline();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_job(input int n, input logic [1:0] am,
                         input logic [1:0] wm, input int idle_fix,
                         input bit stray, input bit restart);
    logic [DW-1:0] wl, al;
    int idle, lat;
    @(negedge clk);
    start = 1'b1; num_tiles = CW'(n);
    cfg_a_mode = am; cfg_w_mode = wm;
    @(negedge clk);
    start = 1'b0; cfg_a_mode = ~am; cfg_w_mode = ~wm; num_tiles = 16'hbeef;
    if (n == 0) begin
      chk("zero_busy", busy, 1);
      chk("zero_done", job_done, 1);
      chk("zero_wen", wen, 0);
      chk("zero_rdy", in_ready, 0);
      @(negedge clk);
      chk("zero_busy_end", busy, 0);
      chk("zero_done_end", job_done, 0);
      chk("zero_en", en, 0);
      chk("zero_cnt", tile_cnt, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk("fill_rdy", in_ready, 1);
      chk("fill_cnt", tile_cnt, i);
      idle = (idle_fix >= 0) ? idle_fix : int'($urandom_range(0, 3));
      for (int j = 0; j < idle; j++) begin
        in_valid = 1'b0;
        disp_done = stray && (j == 0);
        @(negedge clk);
        disp_done = 1'b0;
        chk("bp_rdy", in_ready, 1);
        chk("bp_wen", wen, 0);
        chk("bp_cnt", tile_cnt, i);
      end
      wl = rline(); al = rline();
      in_valid = 1'b1; in_w_data = wl; in_a_data = al;
      @(negedge clk);
      in_valid = 1'b0; in_w_data = rline(); in_a_data = rline();
      chk("wr_wen", wen, 1);
      chk("wr_en", en, 0);
      chk("wr_rdy", in_ready, 0);
      chk("wr_waddr", w_write_address, i % 2);
      chk("wr_aaddr", a_write_address, i % 2);
      chkd("wr_wdata", w_in, wl);
      chkd("wr_adata", a_in, al);
      @(negedge clk);
      chk("is_wen", wen, 0);
      chk("is_en", en, 1);
      chk("is_wraddr", w_read_address, i % 2);
      chk("is_araddr", a_read_address, i % 2);
      chk("is_amode", a_mode, am);
      chk("is_wmode", w_mode, wm);
      chk("is_busy", busy, 1);
      @(negedge clk);
      chk("wait_en", en, 0);
      lat = int'($urandom_range(0, 3));
      for (int j = 0; j < lat; j++) begin
        in_valid = 1'b1;
        if (restart && i == 0 && j == 0) begin
          start = 1'b1; num_tiles = 16'd7;
          cfg_a_mode = ~am; cfg_w_mode = ~wm;
        end
        @(negedge clk);
        start = 1'b0;
        chk("wait_rdy", in_ready, 0);
        chk("wait_wen", wen, 0);
      end
      in_valid = 1'b0;
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
      chk("done_cnt", tile_cnt, i + 1);
      chk("done_jd", job_done, (i == n - 1) ? 1 : 0);
      chk("done_busy", busy, 1);
    end
    @(negedge clk);
    chk("end_jd", job_done, 0);
    chk("end_busy", busy, 0);
    chk("end_cnt", tile_cnt, n);
    chk("end_amode", a_mode, am);
    chk("end_wmode", w_mode, wm);
  endtask

  initial begin
    logic [1:0] am, wm;
    #1;
    chk("rst_outs", {wen, en, in_ready, busy, job_done, tile_cnt,
                     w_write_address, a_write_address, w_read_address,
                     a_read_address, a_mode, w_mode}, 0);
    chkd("rst_w_in", w_in, '0);
    chkd("rst_a_in", a_in, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", in_ready, 0);
    chk("idle_busy", busy, 0);

    run_job(1, 2'b01, 2'b11, 0, 0, 0);
    run_job(4, 2'b10, 2'b00, -1, 0, 0);
    run_job(2, 2'b11, 2'b01, 5, 0, 0);
    run_job(0, 2'b01, 2'b10, -1, 0, 0);
    run_job(3, 2'b00, 2'b10, -1, 0, 1);
    run_job(2, 2'b01, 2'b01, 2, 1, 0);
    for (int r = 0; r < 4; r++) begin
      am = 2'($urandom); wm = 2'($urandom);
      run_job(int'($urandom_range(1, 5)), am, wm, -1, $urandom_range(0, 1) == 1, 0);
    end

    // reset mid-WAIT after a write and a read have been issued
    @(negedge clk);
    start = 1'b1; num_tiles = 16'd3; cfg_a_mode = 2'b11; cfg_w_mode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_w_data = rline(); in_a_data = rline();
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_wen", wen, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {wen, en, in_ready, busy, job_done, tile_cnt,
                         w_write_address, a_write_address, w_read_address,
                         a_read_address, a_mode, w_mode}, 0);
    chkd("mid_rst_w_in", w_in, '0);
    chkd("mid_rst_a_in", a_in, '0);
    @(negedge clk);
    rst_n = 1'b1;
    disp_done = 1'b1;
    @(negedge clk);
    disp_done = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdy", in_ready, 0);
    chk("post_rst_cnt", tile_cnt, 0);
    run_job(3, 2'b10, 2'b01, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
